bus_arbiter: RTL and testbench
==============================

Name: bus_arbiter

Overview:
- Two-master arbiter for the shared single-port system bus: ROM, RAM, EXCP and the DigitalPorts.
- Master 0 is the CPU. Master 1 is a secondary requester such as a DMA or debug loader.
- It owns the bus mux, round-robin arbitration with bounded hold time, and routing of the one-cycle-latency registered read data back to the master that issued the read.
- It sits between the masters and the bus decode/memory logic in the top level.

Parameters:
ADDR_W, 32, bus address width
DATA_W, 32, bus data width
MAX_HOLD, 16, max consecutive granted cycles for an unlocked owner while the other master is requesting (>=2)
HOLD_W, 5, hold counter width, must satisfy 2^HOLD_W > MAX_HOLD

Ports:
clk  input  1  system clock, all state on rising edge
reset  input  1  asynchronous, active-high reset
m0Req  input  1  master 0 requests a bus cycle
m0Lock  input  1  master 0 forbids hold-limit preemption while set
m0We  input  1  master 0 write (1) / read (0)
m0Addr  input  ADDR_W  master 0 byte address
m0WData  input  DATA_W  master 0 write data
m0Gnt  output  1  master 0 owns the bus this cycle
m0RData  output  DATA_W  read data for master 0
m0RValid  output  1  m0RData valid
m1Req, m1Lock, m1We, m1Addr, m1WData, m1Gnt, m1RData, m1RValid  same as master 0, for master 1
busAddress  output  ADDR_W  address to bus decode
busWriteEnable  output  1  bus write strobe
busDataIn  output  DATA_W  write data to bus
busDataOut  input  DATA_W  registered bus read data, valid one cycle after the address

Behaviour:
- State register with three states: IDLE, OWN0, OWN1. Also an rrPtr bit (next preferred master), holdCnt[HOLD_W-1:0], and a read tag.
- Reset values: state=IDLE, rrPtr=0, holdCnt=0, rdTag=none. All mXGnt=0, mXRValid=0, busAddress=0, busWriteEnable=0, busDataIn=0.
- Grants decode from the state register only: m0Gnt=(state==OWN0), m1Gnt=(state==OWN1). The first grant arrives one cycle after the request is seen in IDLE.
- A bus cycle is "accepted" for master X in any cycle where mXGnt & mXReq.
- Bus mux:
  - When accepted: busAddress=mXAddr, busDataIn=mXWData, busWriteEnable=mXWe.
  - Otherwise: busAddress=0, busDataIn=0, busWriteEnable=0.
- Read return:
  - An accepted read (mXWe=0) sets rdTag=X for the next cycle.
  - In that next cycle: mXRValid=1 and mXRData=busDataOut. The other master's RData=0 and RValid=0.
  - Writes never produce RValid.
  - Back-to-back reads give RValid on consecutive cycles.
- IDLE transitions:
  - Both requesting: go to OWN(rrPtr).
  - Only mX requesting: go to OWNX.
  - No requests: stay IDLE.
  - holdCnt is cleared on entry to any OWN state.
- OWNX transitions, Y = the other master:
  - mXReq=0, mYReq=1: go to OWNY directly, no idle bubble.
  - mXReq=0, mYReq=0: go to IDLE.
  - mXReq=1, mYReq=1, mXLock=0, holdCnt==MAX_HOLD-1: go to OWNY (preemption).
  - Otherwise stay; holdCnt increments while mYReq=1, saturating at MAX_HOLD-1, and clears while mYReq=0.
- rrPtr is set to Y whenever OWNX is left or granted from IDLE, so the loser of a tie wins the next tie.
- Locked owner: holdCnt saturates and is not reset by the lock. Preemption happens the cycle after the lock drops if mYReq is still set.
- A master that drops Req while granted loses the grant next cycle. Its accepted read still returns RValid.
- Reset asserted mid-operation clears state immediately. A pending RValid is dropped and not replayed. Bus outputs go to 0 asynchronously.
- No combinational path from mXReq to mXGnt. A combinational path from mXAddr/We/WData to the bus is allowed.

Test Plan:
- Reset, then m0 only reads 0x00000010 with ROM word 0xDEADBEEF -> m0Gnt=1 on cycle 1; busAddress=0x10 on cycle 1; m0RValid=1 with m0RData=0xDEADBEEF on cycle 2; m1 outputs stay 0.
- m0 and m1 both request from IDLE after reset -> OWN0 first. m0 drops after 3 accepts -> m1Gnt the next cycle with no IDLE cycle. Next simultaneous tie -> m1 wins.
- m0 streams requests with lock=0, MAX_HOLD=16, m1 requesting -> exactly 16 m0 grant cycles, then m1Gnt=1. m1 then holds until its hold limit or until it drops Req.
- Same as above with m0Lock=1 for 40 cycles -> m1 never granted in that window. m1Gnt=1 the cycle after m0Lock falls.
- m1 writes 0xA5A5A5A5 to 0xF0000008 -> busWriteEnable=1, busDataIn=0xA5A5A5A5, busAddress=0xF0000008 for one cycle; m1RValid stays 0.
- m0 read accepted, then reset pulsed in the next cycle -> m0RValid=0 and all grants 0 during reset; after release, arbitration restarts from IDLE with rrPtr=0.

Source files
------------

// File: rtl/bus_arbiter.sv
// Two-master round-robin bus arbiter with bounded hold time, bus mux and
// routing of the one-cycle-latency read data back to the master that issued the read.
module bus_arbiter #(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int MAX_HOLD = 16,
    parameter int HOLD_W   = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              m0Req,
    input  logic              m0Lock,
    input  logic              m0We,
    input  logic [ADDR_W-1:0] m0Addr,
    input  logic [DATA_W-1:0] m0WData,
    output logic              m0Gnt,
    output logic [DATA_W-1:0] m0RData,
    output logic              m0RValid,
    input  logic              m1Req,
    input  logic              m1Lock,
    input  logic              m1We,
    input  logic [ADDR_W-1:0] m1Addr,
    input  logic [DATA_W-1:0] m1WData,
    output logic              m1Gnt,
    output logic [DATA_W-1:0] m1RData,
    output logic              m1RValid,
    output logic [ADDR_W-1:0] busAddress,
    output logic              busWriteEnable,
    output logic [DATA_W-1:0] busDataIn,
    input  logic [DATA_W-1:0] busDataOut
);

    typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

    state_t            state_q, state_d;
    logic              rrPtr_q, rrPtr_d;
    logic [HOLD_W-1:0] holdCnt_q, holdCnt_d;
    logic              rdValid_q, rdValid_d;
    logic              rdTag_q, rdTag_d;

    logic   acc0, acc1;
    logic   ownerIsOne, ownReq, otherReq, ownLock;
    state_t otherState;

    assign m0Gnt = (state_q == OWN0);
    assign m1Gnt = (state_q == OWN1);
    assign acc0  = m0Gnt & m0Req;
    assign acc1  = m1Gnt & m1Req;

    assign busAddress     = acc0 ? m0Addr  : (acc1 ? m1Addr  : '0);
    assign busDataIn      = acc0 ? m0WData : (acc1 ? m1WData : '0);
    assign busWriteEnable = (acc0 & m0We) | (acc1 & m1We);

    // Read data is steered by the tag of the read accepted in the previous cycle.
    assign m0RValid = rdValid_q & ~rdTag_q;
    assign m1RValid = rdValid_q & rdTag_q;
    assign m0RData  = m0RValid ? busDataOut : '0;
    assign m1RData  = m1RValid ? busDataOut : '0;

    assign ownerIsOne = (state_q == OWN1);
    assign ownReq     = ownerIsOne ? m1Req  : m0Req;
    assign otherReq   = ownerIsOne ? m0Req  : m1Req;
    assign ownLock    = ownerIsOne ? m1Lock : m0Lock;
    assign otherState = ownerIsOne ? OWN0   : OWN1;

    always_comb begin
        state_d   = state_q;
        rrPtr_d   = rrPtr_q;
        holdCnt_d = holdCnt_q;
        rdValid_d = (acc0 & ~m0We) | (acc1 & ~m1We);
        rdTag_d   = acc1;
        case (state_q)
            IDLE: begin
                if (m0Req && m1Req) begin
                    state_d   = rrPtr_q ? OWN1 : OWN0;
                    rrPtr_d   = ~rrPtr_q;
                    holdCnt_d = '0;
                end else if (m0Req) begin
                    state_d   = OWN0;
                    rrPtr_d   = 1'b1;
                    holdCnt_d = '0;
                end else if (m1Req) begin
                    state_d   = OWN1;
                    rrPtr_d   = 1'b0;
                    holdCnt_d = '0;
                end
            end
            OWN0, OWN1: begin
                if (!ownReq) begin
                    state_d   = otherReq ? otherState : IDLE;
                    rrPtr_d   = ~ownerIsOne;
                    holdCnt_d = '0;
                end else if (otherReq && !ownLock && holdCnt_q == HOLD_LAST) begin
                    state_d   = otherState;
                    rrPtr_d   = ~ownerIsOne;
                    holdCnt_d = '0;
                end else if (otherReq) begin
                    // Saturate so a locked owner is preempted right after unlocking.
                    holdCnt_d = (holdCnt_q == HOLD_LAST) ? holdCnt_q : holdCnt_q + HOLD_W'(1);
                end else begin
                    holdCnt_d = '0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            rrPtr_q   <= 1'b0;
            holdCnt_q <= '0;
            rdValid_q <= 1'b0;
            rdTag_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            rrPtr_q   <= rrPtr_d;
            holdCnt_q <= holdCnt_d;
            rdValid_q <= rdValid_d;
            rdTag_q   <= rdTag_d;
        end
    end

endmodule

// File: tb/tb_bus_arbiter.sv
// Randomized bench for bus_arbiter: an ownership-level reference model is
// compared against every output each cycle, plus directed literal scenarios.
module tb_bus_arbiter;

    localparam int MAXH = 16;

    logic        clk = 1'b0;
    logic        reset;
    logic        m0Req, m0Lock, m0We, m1Req, m1Lock, m1We;
    logic [31:0] m0Addr, m0WData, m1Addr, m1WData;
    logic        m0Gnt, m0RValid, m1Gnt, m1RValid;
    logic [31:0] m0RData, m1RData;
    logic [31:0] busAddress, busDataIn, busDataOut;
    logic        busWriteEnable;

    int checks   = 0;
    int failures = 0;

    // Reference model: current owner (-1 none), tie preference, contested cycles, pending read master.
    int owner, pref, hold, tag;

    bus_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_HOLD(MAXH), .HOLD_W(5)) dut (
        .clk(clk), .reset(reset),
        .m0Req(m0Req), .m0Lock(m0Lock), .m0We(m0We), .m0Addr(m0Addr), .m0WData(m0WData),
        .m0Gnt(m0Gnt), .m0RData(m0RData), .m0RValid(m0RValid),
        .m1Req(m1Req), .m1Lock(m1Lock), .m1We(m1We), .m1Addr(m1Addr), .m1WData(m1WData),
        .m1Gnt(m1Gnt), .m1RData(m1RData), .m1RValid(m1RValid),
        .busAddress(busAddress), .busWriteEnable(busWriteEnable),
        .busDataIn(busDataIn), .busDataOut(busDataOut)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=0x%08h expected=0x%08h", name, actual, expected);
        end
    endtask

    task automatic modelCompare();
        logic [1:0]  req, lock, we, acc;
        logic [31:0] addr[2];
        logic [31:0] wdat[2];
        logic [31:0] eAddr, eData;
        logic        eWe;
        int          x, y;
        req = {m1Req, m0Req};
        lock = {m1Lock, m0Lock};
        we = {m1We, m0We};
        addr[0] = m0Addr;
        addr[1] = m1Addr;
        wdat[0] = m0WData;
        wdat[1] = m1WData;
        acc[0] = (owner == 0) && req[0];
        acc[1] = (owner == 1) && req[1];
        eAddr = acc[0] ? addr[0] : (acc[1] ? addr[1] : 32'h0);
        eData = acc[0] ? wdat[0] : (acc[1] ? wdat[1] : 32'h0);
        eWe   = (acc[0] && we[0]) || (acc[1] && we[1]);
        checkOutput("m0Gnt", 32'(m0Gnt), 32'(owner == 0));
        checkOutput("m1Gnt", 32'(m1Gnt), 32'(owner == 1));
        checkOutput("busAddress", busAddress, eAddr);
        checkOutput("busDataIn", busDataIn, eData);
        checkOutput("busWriteEnable", 32'(busWriteEnable), 32'(eWe));
        checkOutput("m0RValid", 32'(m0RValid), 32'(tag == 0));
        checkOutput("m1RValid", 32'(m1RValid), 32'(tag == 1));
        checkOutput("m0RData", m0RData, (tag == 0) ? busDataOut : 32'h0);
        checkOutput("m1RData", m1RData, (tag == 1) ? busDataOut : 32'h0);
        if (acc[0] && !we[0]) tag = 0;
        else if (acc[1] && !we[1]) tag = 1;
        else tag = -1;
        if (owner < 0) begin
            if (req[0] && req[1]) owner = pref;
            else if (req[0]) owner = 0;
            else if (req[1]) owner = 1;
            if (owner >= 0) begin
                pref = 1 - owner;
                hold = 0;
            end
        end else begin
            x = owner;
            y = 1 - owner;
            if (!req[x]) begin
                owner = req[y] ? y : -1;
                pref = y;
                hold = 0;
            end else if (req[y] && !lock[x] && hold == MAXH - 1) begin
                owner = y;
                pref = y;
                hold = 0;
            end else if (req[y]) begin
                hold = (hold + 1 > MAXH - 1) ? MAXH - 1 : hold + 1;
            end else begin
                hold = 0;
            end
        end
    endtask

    task automatic applyStimulus(input logic r0, input logic l0, input logic w0,
                                 input logic [31:0] a0, input logic [31:0] d0,
                                 input logic r1, input logic l1, input logic w1,
                                 input logic [31:0] a1, input logic [31:0] d1,
                                 input logic [31:0] dout);
        @(negedge clk);
        m0Req = r0; m0Lock = l0; m0We = w0; m0Addr = a0; m0WData = d0;
        m1Req = r1; m1Lock = l1; m1We = w1; m1Addr = a1; m1WData = d1;
        busDataOut = dout;
        #1;
        modelCompare();
    endtask

    task automatic applyIdle();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, $urandom);
    endtask

    task automatic applyBoth(input logic l0);
        applyStimulus(1, l0, 0, $urandom, $urandom, 1, 0, 0, $urandom, $urandom, $urandom);
    endtask

    task automatic doReset();
        @(negedge clk);
        reset = 1'b1;
        #1;
        checkOutput("rst_m0Gnt", 32'(m0Gnt), 32'h0);
        checkOutput("rst_m1Gnt", 32'(m1Gnt), 32'h0);
        checkOutput("rst_m0RValid", 32'(m0RValid), 32'h0);
        checkOutput("rst_m1RValid", 32'(m1RValid), 32'h0);
        checkOutput("rst_busAddress", busAddress, 32'h0);
        checkOutput("rst_busWriteEnable", 32'(busWriteEnable), 32'h0);
        checkOutput("rst_busDataIn", busDataIn, 32'h0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        m0Req = 0; m0Lock = 0; m0We = 0; m0Addr = 0; m0WData = 0;
        m1Req = 0; m1Lock = 0; m1We = 0; m1Addr = 0; m1WData = 0;
        busDataOut = 0;
        owner = -1; pref = 0; hold = 0; tag = -1;
        #1;
        modelCompare();
    endtask

    initial begin
        int cnt0, cnt1;
        bit seen1;
        int p0, p1, lp0, lp1;
        int probs[4] = '{30, 70, 95, 100};
        int lprobs[4] = '{0, 0, 50, 100};
        reset = 1'b1;
        m0Req = 0; m0Lock = 0; m0We = 0; m0Addr = 0; m0WData = 0;
        m1Req = 0; m1Lock = 0; m1We = 0; m1Addr = 0; m1WData = 0;
        busDataOut = 0;
        owner = -1; pref = 0; hold = 0; tag = -1;

        // Single m0 read with one-cycle read return.
        doReset();
        applyStimulus(1, 0, 0, 32'h10, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("t1_c0_m0Gnt", 32'(m0Gnt), 32'h0);
        applyStimulus(1, 0, 0, 32'h10, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("t1_c1_m0Gnt", 32'(m0Gnt), 32'h1);
        checkOutput("t1_c1_busAddress", busAddress, 32'h10);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'hDEADBEEF);
        checkOutput("t1_c2_m0RValid", 32'(m0RValid), 32'h1);
        checkOutput("t1_c2_m0RData", m0RData, 32'hDEADBEEF);
        checkOutput("t1_c2_m1RValid", 32'(m1RValid), 32'h0);
        checkOutput("t1_c2_m1RData", m1RData, 32'h0);
        applyIdle();
        checkOutput("t1_c3_m0RValid", 32'(m0RValid), 32'h0);

        // Tie from IDLE goes to m0; handoff to m1 has no idle bubble.
        doReset();
        for (int i = 0; i < 4; i++) applyBoth(0);
        checkOutput("t2_c3_m0Gnt", 32'(m0Gnt), 32'h1);
        applyStimulus(0, 0, 0, 0, 0, 1, 0, 1, 32'h4, 32'h5, 0);
        checkOutput("t2_c4_m0Gnt", 32'(m0Gnt), 32'h1);
        applyStimulus(0, 0, 0, 0, 0, 1, 0, 1, 32'h4, 32'h5, 0);
        checkOutput("t2_c5_m1Gnt", 32'(m1Gnt), 32'h1);
        checkOutput("t2_c5_m0Gnt", 32'(m0Gnt), 32'h0);
        applyIdle();
        applyIdle();

        // Loser of a tie wins the next tie.
        doReset();
        applyBoth(0);
        applyBoth(0);
        checkOutput("t3_first_m0Gnt", 32'(m0Gnt), 32'h1);
        applyIdle();
        applyBoth(0);
        applyBoth(0);
        checkOutput("t3_second_m1Gnt", 32'(m1Gnt), 32'h1);
        checkOutput("t3_second_m0Gnt", 32'(m0Gnt), 32'h0);

        // Unlocked hold limit: 16 grant cycles each.
        doReset();
        cnt0 = 0; cnt1 = 0; seen1 = 0;
        for (int i = 0; i < 40; i++) begin
            applyBoth(0);
            if (m1Gnt) seen1 = 1;
            if (m0Gnt && !seen1) cnt0++;
            if (m1Gnt) cnt1++;
        end
        checkOutput("t4_m0_run", 32'(cnt0), 32'd16);
        checkOutput("t4_m1_total", 32'(cnt1), 32'd16);

        // Locked owner keeps the bus until the lock drops.
        doReset();
        cnt1 = 0;
        for (int i = 0; i < 40; i++) begin
            applyBoth(1);
            if (m1Gnt) cnt1++;
        end
        checkOutput("t5_locked_m1", 32'(cnt1), 32'd0);
        applyBoth(0);
        checkOutput("t5_unlock_m1Gnt", 32'(m1Gnt), 32'h0);
        applyBoth(0);
        checkOutput("t5_after_m1Gnt", 32'(m1Gnt), 32'h1);

        // m1 write.
        doReset();
        applyStimulus(0, 0, 0, 0, 0, 1, 0, 1, 32'hF0000008, 32'hA5A5A5A5, 0);
        applyStimulus(0, 0, 0, 0, 0, 1, 0, 1, 32'hF0000008, 32'hA5A5A5A5, 0);
        checkOutput("t6_busWriteEnable", 32'(busWriteEnable), 32'h1);
        checkOutput("t6_busDataIn", busDataIn, 32'hA5A5A5A5);
        checkOutput("t6_busAddress", busAddress, 32'hF0000008);
        applyIdle();
        checkOutput("t6_next_busWriteEnable", 32'(busWriteEnable), 32'h0);
        checkOutput("t6_m1RValid", 32'(m1RValid), 32'h0);

        // Reset right after an accepted read drops the pending read; rrPtr restarts at 0.
        doReset();
        applyStimulus(1, 0, 0, 32'h20, 0, 0, 0, 0, 0, 0, 0);
        applyStimulus(1, 0, 0, 32'h20, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("t7_read_accepted", 32'(m0Gnt), 32'h1);
        doReset();
        applyBoth(0);
        applyBoth(0);
        checkOutput("t7_restart_m0Gnt", 32'(m0Gnt), 32'h1);
        checkOutput("t7_restart_m0RValid", 32'(m0RValid), 32'h0);

        // Randomized traffic with varying request and lock pressure.
        for (int seg = 0; seg < 60; seg++) begin
            if (seg == 30) doReset();
            p0 = probs[$urandom_range(3)];
            p1 = probs[$urandom_range(3)];
            lp0 = lprobs[$urandom_range(3)];
            lp1 = lprobs[$urandom_range(3)];
            for (int i = 0; i < 50; i++) begin
                applyStimulus($urandom_range(99) < p0, $urandom_range(99) < lp0, 1'($urandom_range(1)),
                              $urandom, $urandom,
                              $urandom_range(99) < p1, $urandom_range(99) < lp1, 1'($urandom_range(1)),
                              $urandom, $urandom, $urandom);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
